reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_mp_pkg.sv | 12 +
 rtl/reg_file_mp_scoreboard.sv | 42 ++++
 rtl/reg_file_mp.sv | 139 +++++++++++++
 tb/tb_reg_file_mp.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_mp_pkg.sv
// Shared types and default widths for the multi-port register file.
package reg_file_mp_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/reg_file_mp_scoreboard.sv
// Per-entry pending-write scoreboard with NRD combinational lookup ports.
module reg_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_en,
  input  logic [ADDR_W-1:0]     set_adr,
  input  logic                  clr_en,
  input  logic [ADDR_W-1:0]     clr_adr,
  input  logic                  flush,
  input  logic [NRD*ADDR_W-1:0] rd_adr,
  output logic [NRD-1:0]        pend
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] bits_q;
  logic [DEPTH-1:0] bits_d;

  // Set is applied after clear so a same-address set/clear pair ends set.
  always_comb begin
    bits_d = bits_q;
    if (flush) begin
      bits_d = '0;
    end else begin
      if (clr_en) bits_d[clr_adr] = 1'b0;
      if (set_en) bits_d[set_adr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bits_q <= '0;
    else        bits_q <= bits_d;
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_lookup
    assign pend[gi] = bits_q[rd_adr[gi*ADDR_W +: ADDR_W]];
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with write bypass, pending scoreboard and a
// sequential one-entry-per-cycle clear engine.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  WE,
  input  logic [ADDR_W-1:0]     WAdr,
  input  logic [DATA_W-1:0]     Din,
  input  logic                  SetPend,
  input  logic [ADDR_W-1:0]     SetAdr,
  input  logic [NRD*ADDR_W-1:0] RAdr,
  output logic [NRD*DATA_W-1:0] RData,
  output logic [NRD-1:0]        Pend,
  input  logic                  ClrReq,
  output logic                  Busy
);

  localparam int DEPTH = 1 << ADDR_W;

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              idle;
  logic              cmd_ok;
  logic              wr_acc;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wadr;
  logic [DATA_W-1:0] mem_wdat;
  logic [NRD-1:0]    sb_pend;

  assign idle   = (state_q == IDLE);
  // The ClrReq cycle itself and the whole clear sweep swallow WE/SetPend.
  assign cmd_ok = idle && !ClrReq;
  assign wr_acc = cmd_ok && WE && !((ZERO_REG != 0) && (WAdr == '0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (ClrReq) begin
          state_d = CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign Busy = busy_q;

  assign mem_we   = wr_acc || !idle;
  assign mem_wadr = idle ? WAdr : cnt_q;
  assign mem_wdat = idle ? Din : '0;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[mem_wadr] <= mem_wdat;
    end
  end

  reg_scoreboard #(
    .ADDR_W (ADDR_W),
    .NRD    (NRD)
  ) u_scoreboard (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .set_en  (cmd_ok && SetPend),
    .set_adr (SetAdr),
    .clr_en  (wr_acc),
    .clr_adr (WAdr),
    .flush   (idle && ClrReq),
    .rd_adr  (RAdr),
    .pend    (sb_pend)
  );

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [ADDR_W-1:0] rd_adr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_pend;

    assign rd_adr = RAdr[gi*ADDR_W +: ADDR_W];

    // Masking order: reset/clear/zero-register override any bypass hit.
    always_comb begin
      rd_data = mem_q[rd_adr];
      rd_pend = sb_pend[gi];
      if ((BYPASS != 0) && wr_acc && (WAdr == rd_adr)) begin
        rd_data = Din;
        rd_pend = 1'b0;
      end
      if (!Rst_n || busy_q || ((ZERO_REG != 0) && (rd_adr == '0))) begin
        rd_data = '0;
        rd_pend = 1'b0;
      end
    end

    assign RData[gi*DATA_W +: DATA_W] = rd_data;
    assign Pend[gi]                   = rd_pend;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed table, clear/reset sequences,
// random traffic against an array model, and a 4-port no-bypass instance.
module tb_reg_file_mp;

  logic        Clk;
  logic        Rst_n;
  logic        WE, SetPend, ClrReq;
  logic [4:0]  WAdr, SetAdr;
  logic [31:0] Din;
  logic [9:0]  RAdr;
  wire  [63:0] RData;
  wire  [1:0]  Pend;
  wire         Busy;

  logic         WE4, SetPend4, ClrReq4;
  logic [4:0]   WAdr4, SetAdr4;
  logic [31:0]  Din4;
  logic [19:0]  RAdr4;
  wire  [127:0] RData4;
  wire  [3:0]   Pend4;
  wire          Busy4;

  int total = 0;
  int bad   = 0;

  reg_file_mp u_dut (
    .Clk(Clk), .Rst_n(Rst_n), .WE(WE), .WAdr(WAdr), .Din(Din),
    .SetPend(SetPend), .SetAdr(SetAdr), .RAdr(RAdr), .RData(RData),
    .Pend(Pend), .ClrReq(ClrReq), .Busy(Busy)
  );

  reg_file_mp #(.NRD(4), .BYPASS(0)) u_dut4 (
    .Clk(Clk), .Rst_n(Rst_n), .WE(WE4), .WAdr(WAdr4), .Din(Din4),
    .SetPend(SetPend4), .SetAdr(SetAdr4), .RAdr(RAdr4), .RData(RData4),
    .Pend(Pend4), .ClrReq(ClrReq4), .Busy(Busy4)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Behavioural model: plain arrays plus a count of entries still to clear.
  logic [31:0] m_mem  [32];
  bit          m_pend [32];
  int          m_left;

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
    m_left = 0;
  endfunction

  function automatic void m_edge();
    if (m_left > 0) begin
      m_mem[32 - m_left] = '0;
      m_left--;
    end else if (ClrReq) begin
      for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      m_left = 32;
    end else begin
      if (WE && WAdr != 0) begin
        m_mem[WAdr]  = Din;
        m_pend[WAdr] = 1'b0;
      end
      if (SetPend) m_pend[SetAdr] = 1'b1;
    end
  endfunction

  function automatic logic [31:0] m_data(input logic [4:0] a);
    if (m_left > 0 || a == 0) return '0;
    if (WE && !ClrReq && WAdr == a) return Din;
    return m_mem[a];
  endfunction

  function automatic logic m_pnd(input logic [4:0] a);
    if (m_left > 0 || a == 0) return 1'b0;
    if (WE && !ClrReq && WAdr == a) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    m_edge();
    #1;
  endtask

  task automatic idle_inputs();
    WE = 1'b0; SetPend = 1'b0; ClrReq = 1'b0;
    WAdr = '0; SetAdr = '0; Din = '0;
  endtask

  task automatic check_model(input string tag);
    @(negedge Clk);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_data"}, 64'(RData[k*32 +: 32]), 64'(m_data(RAdr[k*5 +: 5])));
      chk({tag, "_pend"}, 64'(Pend[k]), 64'(m_pnd(RAdr[k*5 +: 5])));
    end
    chk({tag, "_busy"}, 64'(Busy), 64'(m_left > 0));
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] din;
    logic        sp;
    logic [4:0]  sa;
    logic [4:0]  r0, r1;
    logic [31:0] d0, d1;
    logic        p0, p1;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 5'd7, 5'd7, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd7, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0};
    tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0};
    tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0};
    tbl[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0};
    tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 5'd3, 5'd7, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd3, 32'h0,        32'h0,        1'b1, 1'b1};
    tbl[8]  = '{1'b1, 5'd3, 32'h55,       1'b0, 5'd0, 5'd3, 5'd7, 32'h55,       32'hDEADBEEF, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd3, 32'h55,       32'h55,       1'b0, 1'b0};
    tbl[10] = '{1'b1, 5'd3, 32'h66,       1'b1, 5'd3, 5'd3, 5'd3, 32'h66,       32'h66,       1'b0, 1'b0};
    tbl[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd3, 32'h66,       32'h66,       1'b1, 1'b1};

    m_reset();
    idle_inputs();
    WE4 = 1'b0; SetPend4 = 1'b0; ClrReq4 = 1'b0;
    WAdr4 = '0; SetAdr4 = '0; Din4 = '0; RAdr4 = '0;

    // Reset: outputs zero even with a bypassable write presented.
    Rst_n = 1'b0;
    WE = 1'b1; WAdr = 5'd7; Din = 32'hCAFEF00D; RAdr = {5'd7, 5'd7};
    #2;
    chk("rst_rdata", 64'(RData), 64'd0);
    chk("rst_pend",  64'(Pend),  64'd0);
    chk("rst_busy",  64'(Busy),  64'd0);
    $display("reset: rdata=%0h pend=%0b busy=%0b", RData, Pend, Busy);
    #10;
    idle_inputs();
    Rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      WE = tbl[i].we; WAdr = tbl[i].wa; Din = tbl[i].din;
      SetPend = tbl[i].sp; SetAdr = tbl[i].sa;
      RAdr = {tbl[i].r1, tbl[i].r0};
      @(negedge Clk);
      chk("tbl_d0", 64'(RData[31:0]),  64'(tbl[i].d0));
      chk("tbl_d1", 64'(RData[63:32]), 64'(tbl[i].d1));
      chk("tbl_p0", 64'(Pend[0]),      64'(tbl[i].p0));
      chk("tbl_p1", 64'(Pend[1]),      64'(tbl[i].p1));
      $display("vec %0d: d0=%0h d1=%0h pend=%0b", i, RData[31:0], RData[63:32], Pend);
      tick();
    end
    idle_inputs();

    // Fill 1..31, then clear; a write and a pend-set mid-clear must vanish.
    for (int i = 1; i < 32; i++) begin
      WE = 1'b1; WAdr = 5'(i); Din = i;
      tick();
    end
    idle_inputs();
    ClrReq = 1'b1;
    RAdr = {5'd9, 5'd5};
    @(negedge Clk);
    chk("clr_req_busy", 64'(Busy), 64'd0);
    tick();
    begin
      int n;
      n = 0;
      while (Busy === 1'b1 && n < 40) begin
        idle_inputs();
        if (n == 5) begin
          WE = 1'b1; WAdr = 5'd2; Din = 32'hFFFF;
          SetPend = 1'b1; SetAdr = 5'd9; ClrReq = 1'b1;
          @(negedge Clk);
          chk("clr_mid_rdata", 64'(RData), 64'd0);
          chk("clr_mid_pend",  64'(Pend),  64'd0);
        end
        tick();
        n++;
      end
      idle_inputs();
      chk("clr_busy_cycles", 64'(n), 64'd32);
      $display("clear: busy for %0d cycles", n);
    end
    for (int a = 0; a < 32; a++) begin
      RAdr = {5'(a), 5'(a)};
      @(negedge Clk);
      chk("clr_entry", 64'(RData[31:0]), 64'd0);
      chk("clr_pend",  64'(Pend[0]),     64'd0);
      tick();
    end

    // Reset in clear cycle 10: Busy drops with no edge, no resumption.
    WE = 1'b1; WAdr = 5'd4; Din = 32'h44;
    tick();
    idle_inputs();
    ClrReq = 1'b1;
    tick();
    ClrReq = 1'b0;
    repeat (10) tick();
    chk("mid_busy_before", 64'(Busy), 64'd1);
    #2;
    Rst_n = 1'b0;
    #1;
    m_reset();
    chk("mid_rst_busy",  64'(Busy),  64'd0);
    chk("mid_rst_rdata", 64'(RData), 64'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    WE = 1'b1; WAdr = 5'd5; Din = 32'hA5;
    RAdr = {5'd5, 5'd4};
    tick();
    idle_inputs();
    @(negedge Clk);
    chk("post_rst_d5", 64'(RData[63:32]), 64'hA5);
    chk("post_rst_d4", 64'(RData[31:0]),  64'd0);
    chk("post_rst_busy", 64'(Busy), 64'd0);
    $display("post reset: entry5=%0h busy=%0b", RData[63:32], Busy);
    repeat (3) tick();
    chk("post_rst_no_resume", 64'(Busy), 64'd0);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      WE      = 1'($urandom_range(0, 1));
      WAdr    = 5'($urandom_range(0, 7));
      Din     = $urandom;
      SetPend = ($urandom_range(0, 2) == 0);
      SetAdr  = 5'($urandom_range(0, 7));
      ClrReq  = ($urandom_range(0, 79) == 0);
      RAdr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      check_model("rnd");
      tick();
    end
    idle_inputs();
    while (m_left > 0) tick();
    $display("random phase done");

    // Four ports, no bypass: old values in the write cycle, new value next.
    for (int i = 1; i <= 4; i++) begin
      WE4 = 1'b1; WAdr4 = 5'(i); Din4 = 32'h11 * i;
      tick();
    end
    for (int k = 0; k < 4; k++) RAdr4[k*5 +: 5] = 5'(k + 1);
    WE4 = 1'b1; WAdr4 = 5'd2; Din4 = 32'hBB;
    @(negedge Clk);
    for (int k = 0; k < 4; k++)
      chk("nrd4_old", 64'(RData4[k*32 +: 32]), 64'(32'h11 * (k + 1)));
    tick();
    WE4 = 1'b0;
    @(negedge Clk);
    for (int k = 0; k < 4; k++)
      chk("nrd4_new", 64'(RData4[k*32 +: 32]), (k == 1) ? 64'hBB : 64'(32'h11 * (k + 1)));
    $display("nrd4: port1=%0h", RData4[63:32]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
